count_seq_ctrl: RTL and testbench
=================================

Name: count_seq_ctrl

Overview:
- Command-driven sequencer for a WIDTH-bit up/down counter. It owns the counter and drives its enable, direction and load.
- Accepts one command at a time over a valid/ready handshake:
  - GOTO: count monotonically to a target value.
  - SWEEP: load a low bound, then ping-pong between low and high bounds a programmed number of times.
- Signals completion with a one-cycle done pulse and an error flag.
- Sits between a test or control host and the counter datapath.

Parameters:
- WIDTH, 4: counter and bound width.
- REP_W, 4: width of the sweep repetition count.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-low. Sampled only on posedge clk.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command. Equal to (state==IDLE).
- cmd_mode  input  1  0 = GOTO, 1 = SWEEP.
- cmd_lo  input  WIDTH  SWEEP low bound; ignored in GOTO.
- cmd_hi  input  WIDTH  SWEEP high bound; GOTO target.
- cmd_reps  input  REP_W  SWEEP repetitions; ignored in GOTO.
- abort  input  1  terminate the active command.
- count  output  WIDTH  counter value (registered).
- ud  output  1  direction: 1 = up, 0 = down (registered).
- busy  output  1  high when state is not IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid only while done=1: illegal command or abort.

Behaviour:
- Reset: rst==0 at posedge forces state=IDLE, count=0, ud=1, done=0, err=0, busy=0. Any active command is discarded. Reset has priority over every other input, including mid-command.
- Accept: a command is accepted at a posedge with cmd_valid & cmd_ready & rst. On acceptance, mode, lo, hi and reps are latched. cmd_valid is ignored when not IDLE.
- GOTO, evaluated against the registered count at acceptance:
  - hi > count: state=UP, ud=1.
  - hi < count: state=DOWN, ud=0.
  - equal: state=DONE, count unchanged.
- SWEEP, checked at acceptance:
  - lo > hi or reps==0: state=DONE with err=1 (lo>hi) or err=0 (reps==0); count unchanged.
  - Otherwise: count<=lo, ud=1, state=UP, reps_left=reps.
- UP:
  - GOTO: if count==hi, go to DONE; else count+1.
  - SWEEP: if count==hi, go to DOWN with ud<=0 and count held (turnaround cycle); else count+1.
- DOWN:
  - GOTO: if count==hi (target), go to DONE; else count-1.
  - SWEEP: if count==lo, decrement reps_left. If reps_left was 1, go to DONE; else go to UP with ud<=1 and count held. Otherwise count-1.
- Step rate: exactly one count step per cycle while in UP/DOWN.
- Wrap-around: the controller never steps past 0 or 2^WIDTH-1. All bounds are within range, so no wrap occurs.
- lo==hi: each leg takes one hold cycle, so each rep takes 2 cycles.
- abort: while in UP/DOWN, the next state is DONE with err=1 and count holds. abort in IDLE or DONE has no effect. If abort coincides with the natural terminal condition, err=1.
- DONE: lasts exactly 1 cycle with done=1, busy=1, cmd_ready=0. The next state is IDLE.
- Hold values:
  - ud holds its last value in IDLE and DONE.
  - count holds in IDLE and DONE.
- Latency: a new command can be accepted on the first cycle after DONE.

Decomposition:
- Package count_seq_pkg:
  - state encoding: IDLE, UP, DOWN, DONE.
  - MODE_GOTO=1'b0, MODE_SWEEP=1'b1.
- Sub-module updown_counter_en, with ports clk, rst (sync, active-low), en, ud, load, load_val, count:
  - Precedence: load > en.
  - Wraps modulo 2^WIDTH if enabled at a boundary.
  - The controller guarantees it is never enabled at a boundary.
- The FSM, latched command registers and reps_left live in count_seq_ctrl.

Test Plan:
- Reset mid-SWEEP: accept SWEEP lo=2, hi=5, reps=3, then pull rst low at cycle 4 -> count=0, ud=1, busy=0, cmd_ready=1 on the next cycle; no done pulse.
- GOTO up then down: from count=0, GOTO hi=9 -> count steps 1..9 on consecutive cycles with ud=1, then done=1, err=0. Next, GOTO hi=3 -> ud=0, steps 8..3, then done.
- SWEEP lo=2, hi=5, reps=2, accepted at T0:
  - T1 count=2; T4 count=5; T5 hold 5 with ud=0; T8 count=2.
  - T9 hold with ud=1; T12 count=5; T13 hold; T16 count=2.
  - T17 done=1, err=0; T18 cmd_ready=1.
- Illegal and degenerate commands:
  - SWEEP lo=7, hi=3 -> done=1, err=1 on the cycle after acceptance, count unchanged.
  - SWEEP reps=0 -> done=1, err=0.
  - GOTO to the current count -> done next cycle, no count change.
- Abort: GOTO hi=15 from 0, abort at count=6 -> count holds 6, done=1, err=1. cmd_valid asserted during busy is not accepted (cmd_ready=0).
- Boundary: SWEEP lo=0, hi=15, reps=1 -> count reaches 15 and 0 without wrapping; lo=hi=4, reps=3 -> 6 cycles of count=4 with ud toggling, then done.

Source files
------------

// File: rtl/count_seq_ctrl_pkg.sv
// Shared types and constants for the counter sequencer slice.
package count_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic MODE_GOTO  = 1'b0;
    localparam logic MODE_SWEEP = 1'b1;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_REP_W = 4;

endpackage

// File: rtl/count_seq_ctrl_if.sv
// Command/status bundle between a host (master) and the sequencer (slave).
interface count_seq_ctrl_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned REP_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_mode;
    logic [WIDTH-1:0] cmd_lo;
    logic [WIDTH-1:0] cmd_hi;
    logic [REP_W-1:0] cmd_reps;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             ud;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output cmd_valid, cmd_mode, cmd_lo, cmd_hi, cmd_reps, abort,
        input  cmd_ready, count, ud, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_lo, cmd_hi, cmd_reps, abort,
        output cmd_ready, count, ud, busy, done, err
    );
endinterface

// File: rtl/count_seq_ctrl_updown_counter_en.sv
// Loadable up/down counter; load wins over enable, wraps modulo 2^WIDTH.
module updown_counter_en #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ud,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = ud ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/count_seq_ctrl.sv
// Command sequencer: runs GOTO / SWEEP commands on an up/down counter.
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned REP_W = DEF_REP_W
) (
    input logic              clk,
    input logic              rst,
    count_seq_ctrl_if.slave  bus
);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [REP_W-1:0] reps_left_q, reps_left_d;
    logic             ud_q, ud_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    logic             cnt_en_c;
    logic             cnt_up_c;
    logic             cnt_load_c;
    logic [WIDTH-1:0] cnt_load_val_c;
    logic [WIDTH-1:0] cnt_val;

    updown_counter_en #(.WIDTH(WIDTH)) u_counter (
        .clk      (clk),
        .rst      (rst),
        .en       (cnt_en_c),
        .ud       (cnt_up_c),
        .load     (cnt_load_c),
        .load_val (cnt_load_val_c),
        .count    (cnt_val)
    );

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        lo_d           = lo_q;
        hi_d           = hi_q;
        reps_left_d    = reps_left_q;
        ud_d           = ud_q;
        err_d          = 1'b0;
        cnt_en_c       = 1'b0;
        cnt_up_c       = 1'b1;
        cnt_load_c     = 1'b0;
        cnt_load_val_c = lo_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    mode_d      = bus.cmd_mode;
                    lo_d        = bus.cmd_lo;
                    hi_d        = bus.cmd_hi;
                    reps_left_d = bus.cmd_reps;
                    if (bus.cmd_mode == MODE_GOTO) begin
                        if (bus.cmd_hi > cnt_val) begin
                            state_d = UP;
                            ud_d    = 1'b1;
                        end else if (bus.cmd_hi < cnt_val) begin
                            state_d = DOWN;
                            ud_d    = 1'b0;
                        end else begin
                            state_d = DONE;
                        end
                    end else if (bus.cmd_lo > bus.cmd_hi) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else if (bus.cmd_reps == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d        = UP;
                        ud_d           = 1'b1;
                        cnt_load_c     = 1'b1;
                        cnt_load_val_c = bus.cmd_lo;
                    end
                end
            end
            UP: begin
                if (bus.abort) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if (cnt_val == hi_q) begin
                    if (mode_q == MODE_GOTO) begin
                        state_d = DONE;
                    end else begin
                        // turnaround: hold count one cycle while direction flips
                        state_d = DOWN;
                        ud_d    = 1'b0;
                    end
                end else begin
                    cnt_en_c = 1'b1;
                    cnt_up_c = 1'b1;
                end
            end
            DOWN: begin
                if (bus.abort) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if (mode_q == MODE_GOTO) begin
                    if (cnt_val == hi_q) begin
                        state_d = DONE;
                    end else begin
                        cnt_en_c = 1'b1;
                        cnt_up_c = 1'b0;
                    end
                end else if (cnt_val == lo_q) begin
                    reps_left_d = reps_left_q - REP_W'(1);
                    if (reps_left_q == REP_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = UP;
                        ud_d    = 1'b1;
                    end
                end else begin
                    cnt_en_c = 1'b1;
                    cnt_up_c = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d  = (state_d == DONE);
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            mode_q      <= MODE_GOTO;
            lo_q        <= '0;
            hi_q        <= '0;
            reps_left_q <= '0;
            ud_q        <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            reps_left_q <= reps_left_d;
            ud_q        <= ud_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.count     = cnt_val;
    assign bus.ud        = ud_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.cmd_ready = ready_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: directed plan steps plus random commands vs a trajectory model.
module tb_count_seq_ctrl;
    import count_seq_pkg::*;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned REP_W = 4;

    typedef struct {
        int count;
        bit ud;
        bit busy;
        bit done;
        bit err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    count_seq_ctrl_if #(.WIDTH(WIDTH), .REP_W(REP_W)) bus ();

    count_seq_ctrl #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   m_count;
    bit   m_ud;
    exp_t traj[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_entry(input string tag, input exp_t e);
        chk({tag, ".count"}, 32'(bus.count), 32'(e.count));
        chk({tag, ".ud"},    32'(bus.ud),    32'(e.ud));
        chk({tag, ".busy"},  32'(bus.busy),  32'(e.busy));
        chk({tag, ".ready"}, 32'(bus.cmd_ready), 32'(!e.busy));
        chk({tag, ".done"},  32'(bus.done),  32'(e.done));
        if (e.done) chk({tag, ".err"}, 32'(bus.err), 32'(e.err));
    endtask

    // Expected per-cycle outputs after acceptance, from the command rules.
    task automatic build_traj(input bit mode, input int lo, input int hi, input int reps,
                              input int abort_at);
        exp_t e;
        int   lc;
        bit   lud;
        bit   ab;
        traj.delete();
        e.busy = 1'b1; e.done = 1'b0; e.err = 1'b0;
        if (mode == MODE_GOTO) begin
            if (hi > m_count) begin
                for (int v = m_count; v <= hi; v++) begin e.count = v; e.ud = 1'b1; traj.push_back(e); end
            end else if (hi < m_count) begin
                for (int v = m_count; v >= hi; v--) begin e.count = v; e.ud = 1'b0; traj.push_back(e); end
            end
        end else if (lo <= hi && reps != 0) begin
            for (int r = 0; r < reps; r++) begin
                for (int v = lo; v <= hi; v++) begin e.count = v; e.ud = 1'b1; traj.push_back(e); end
                for (int v = hi; v >= lo; v--) begin e.count = v; e.ud = 1'b0; traj.push_back(e); end
            end
        end
        ab = 1'b0;
        if (abort_at >= 0 && abort_at < traj.size()) begin
            ab = 1'b1;
            while (traj.size() > abort_at + 1) void'(traj.pop_back());
        end
        if (traj.size() > 0) begin lc = traj[$].count; lud = traj[$].ud; end
        else begin lc = m_count; lud = m_ud; end
        e.count = lc; e.ud = lud; e.busy = 1'b1; e.done = 1'b1;
        e.err   = ab || (mode == MODE_SWEEP && lo > hi);
        traj.push_back(e);
        m_count = lc;
        m_ud    = lud;
    endtask

    // Call at a negedge while idle; returns at the first idle negedge afterwards.
    task automatic do_cmd(input string tag, input bit mode, input int lo, input int hi,
                          input int reps, input int abort_at, input bit junk);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = mode;
        bus.cmd_lo    = WIDTH'(lo);
        bus.cmd_hi    = WIDTH'(hi);
        bus.cmd_reps  = REP_W'(reps);
        bus.abort     = 1'b0;
        build_traj(mode, lo, hi, reps, abort_at);
        for (int i = 0; i < traj.size(); i++) begin
            @(negedge clk);
            bus.cmd_valid = junk;
            bus.cmd_mode  = 1'($urandom);
            bus.cmd_lo    = WIDTH'($urandom);
            bus.cmd_hi    = WIDTH'($urandom);
            bus.cmd_reps  = REP_W'($urandom);
            bus.abort     = 1'b0;
            check_entry(tag, traj[i]);
            if (i == abort_at && !traj[i].done) bus.abort = 1'b1;
            if (traj[i].done && junk) bus.abort = 1'($urandom);
        end
        @(negedge clk);
        bus.abort = 1'b0;
        chk({tag, ".idle_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, ".idle_busy"},  32'(bus.busy),      32'd0);
        chk({tag, ".idle_done"},  32'(bus.done),      32'd0);
        chk({tag, ".idle_count"}, 32'(bus.count),     32'(m_count));
        chk({tag, ".idle_ud"},    32'(bus.ud),        32'(m_ud));
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        int lo, hi, reps, ab, mode, n;
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_mode  = MODE_GOTO;
        bus.cmd_lo    = '0;
        bus.cmd_hi    = '0;
        bus.cmd_reps  = '0;
        bus.abort     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.count", 32'(bus.count),     32'd0);
        chk("reset.ud",    32'(bus.ud),        32'd1);
        chk("reset.busy",  32'(bus.busy),      32'd0);
        chk("reset.done",  32'(bus.done),      32'd0);
        chk("reset.ready", 32'(bus.cmd_ready), 32'd1);
        rst = 1'b1;
        m_count = 0;
        m_ud    = 1'b1;
        @(negedge clk);

        // reset in the middle of a sweep
        bus.cmd_valid = 1'b1; bus.cmd_mode = MODE_SWEEP;
        bus.cmd_lo = WIDTH'(2); bus.cmd_hi = WIDTH'(5); bus.cmd_reps = REP_W'(3);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("rstmid.t1_count", 32'(bus.count), 32'd2);
        chk("rstmid.t1_busy",  32'(bus.busy),  32'd1);
        repeat (3) @(negedge clk);
        chk("rstmid.t4_count", 32'(bus.count), 32'd5);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rstmid.count", 32'(bus.count),     32'd0);
        chk("rstmid.ud",    32'(bus.ud),        32'd1);
        chk("rstmid.busy",  32'(bus.busy),      32'd0);
        chk("rstmid.ready", 32'(bus.cmd_ready), 32'd1);
        chk("rstmid.done",  32'(bus.done),      32'd0);
        @(negedge clk);
        chk("rstmid.done2", 32'(bus.done), 32'd0);
        chk("rstmid.busy2", 32'(bus.busy), 32'd0);

        do_cmd("goto9",       MODE_GOTO,  0, 9,  0, -1, 1'b1);
        do_cmd("goto3",       MODE_GOTO,  0, 3,  0, -1, 1'b0);
        do_cmd("sweep2_5x2",  MODE_SWEEP, 2, 5,  2, -1, 1'b1);
        do_cmd("sweep_bad",   MODE_SWEEP, 7, 3,  2, -1, 1'b0);
        do_cmd("sweep_rep0",  MODE_SWEEP, 1, 6,  0, -1, 1'b1);
        do_cmd("goto_same",   MODE_GOTO,  0, 2,  0, -1, 1'b0);
        do_cmd("goto0",       MODE_GOTO,  0, 0,  0, -1, 1'b1);
        do_cmd("goto15_ab6",  MODE_GOTO,  0, 15, 0, 6,  1'b1);
        do_cmd("abort_term",  MODE_GOTO,  0, 8,  0, 2,  1'b0);
        do_cmd("goto0b",      MODE_GOTO,  0, 0,  0, -1, 1'b0);
        do_cmd("sweep0_15",   MODE_SWEEP, 0, 15, 1, -1, 1'b1);
        do_cmd("sweep4_4x3",  MODE_SWEEP, 4, 4,  3, -1, 1'b1);

        for (int k = 0; k < 40; k++) begin
            mode = int'($urandom_range(0, 1));
            lo   = int'($urandom_range(0, 15));
            hi   = int'($urandom_range(0, 15));
            reps = int'($urandom_range(0, 3));
            ab   = -1;
            if ($urandom_range(0, 3) == 0) begin
                n  = (mode == 1) ? (hi - lo + 1) * 2 * reps : 16;
                ab = (n > 0) ? int'($urandom_range(0, n)) : 0;
            end
            do_cmd("random", 1'(mode), lo, hi, reps, ab, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
